// File: rtl/crc_engine_if.sv
// Stream and result bundle for crc_engine.
// master drives beats; slave returns CRC and status.
interface crc_engine_if #(
   parameter int CRC_W = 16,
   parameter int DIN_W = 8
);
   logic             start_i;
   logic [DIN_W-1:0] din_i;
   logic             din_vld_i;
   logic             din_last_i;
   logic [CRC_W-1:0] crc_o;
   logic             crc_vld_o;
   logic             chk_ok_o;
   logic             busy_o;
   logic             err_o;

   modport master (
      output start_i,
      output din_i,
      output din_vld_i,
      output din_last_i,
      input  crc_o,
      input  crc_vld_o,
      input  chk_ok_o,
      input  busy_o,
      input  err_o
   );

   modport slave (
      input  start_i,
      input  din_i,
      input  din_vld_i,
      input  din_last_i,
      output crc_o,
      output crc_vld_o,
      output chk_ok_o,
      output busy_o,
      output err_o
   );
endinterface

// File: rtl/crc_engine.sv
// Parametrised multi-bit-per-cycle CRC generator/checker
// with frame control, residue check and protocol-error flag.
module crc_engine #(
   parameter int               CRC_W       = 16,
   parameter logic [CRC_W-1:0] POLY        = 16'h8005,
   parameter logic [CRC_W-1:0] INIT        = 16'hFFFF,
   parameter logic [CRC_W-1:0] XOR_OUT     = 16'hFFFF,
   parameter int               DIN_W       = 8,
   parameter bit               REFLECT_IN  = 1'b1,
   parameter bit               REFLECT_OUT = 1'b1,
   parameter logic [CRC_W-1:0] RESIDUE     = 16'h800D
) (
   input logic         clk,
   input logic         reset_l,
   crc_engine_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CRC_W-1:0] crc_q;
   logic [CRC_W-1:0] crc_base;
   logic [CRC_W-1:0] crc_step;
   logic [CRC_W-1:0] crc_nxt;
   logic [CRC_W-1:0] crc_out;
   logic             chk_ok;
   logic             err_q;
   logic             take;
   logic             fin;
   logic             bad;

   function automatic logic [CRC_W-1:0] step(
      input logic [CRC_W-1:0] r,
      input logic [DIN_W-1:0] d
   );
      logic [CRC_W-1:0] c;
      logic             b;
      logic             fb;
      c = r;
      for (int i = 0; i < DIN_W; i++) begin
         b  = REFLECT_IN ? d[i] : d[DIN_W-1-i];
         fb = c[CRC_W-1] ^ b;
         c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return c;
   endfunction

   function automatic logic [CRC_W-1:0] bitrev(
      input logic [CRC_W-1:0] r
   );
      logic [CRC_W-1:0] o;
      for (int i = 0; i < CRC_W; i++)
         o[i] = r[CRC_W-1-i];
      return o;
   endfunction

   // A start always rebases on INIT, even when it aborts a frame.
   always_comb begin
      crc_base = bus.start_i ? INIT : crc_q;
      crc_step = step(crc_base, bus.din_i);
      take     = bus.din_vld_i &
                 (bus.start_i | (state == RUN));
      fin      = take & bus.din_last_i;
      bad      = bus.din_vld_i & ~bus.start_i &
                 (state != RUN);
      crc_nxt  = take ? crc_step : crc_base;
   end

   always_comb begin
      state_nxt = state;
      if (fin)
         state_nxt = DONE;
      else if (bus.start_i)
         state_nxt = RUN;
      else if (state != RUN)
         state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state   <= IDLE;
         crc_q   <= INIT;
         crc_out <= '0;
         chk_ok  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         crc_q <= crc_nxt;
         err_q <= bad;
         if (fin) begin
            crc_out <= (REFLECT_OUT ? bitrev(crc_nxt)
                                    : crc_nxt) ^ XOR_OUT;
            chk_ok  <= (crc_nxt == RESIDUE);
         end else if (bus.start_i) begin
            crc_out <= '0;
            chk_ok  <= 1'b0;
         end
      end
   end

   assign bus.crc_o     = crc_out;
   assign bus.chk_ok_o  = chk_ok;
   assign bus.crc_vld_o = (state == DONE);
   assign bus.busy_o    = (state == RUN);
   assign bus.err_o     = err_q;

endmodule
